// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout-bus receive deserializer.
// Build option RO_DEMUX_LAST_EN adds the per-channel last-sample register.
package ro_pkg;

    localparam int N_CH_DEF = 17;
    localparam int W_DEF    = 8;

`ifdef RO_DEMUX_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    function automatic int ch_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int fill_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Trailing-ones count of c, saturating at n (all ones = idle slot)
    function automatic int tones(input logic [31:0] c, input int n);
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && k == i && c[i]) begin
                k = i + 1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/ro_demux_if.sv
// Stream bundle between the bus retiming flop, ro_demux and the back-end.
// Build option RO_DEMUX_LAST_EN adds ch_last.
interface ro_demux_if
    import ro_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF
);
    localparam int CH_W = ch_w(N_CH);

    logic            en;
    logic            sync;
    logic            bus_in;
    logic            slot_valid;
    logic [CH_W-1:0] slot_ch;
    logic            slot_bit;
    logic            word_valid;
    logic [CH_W-1:0] word_ch;
    logic [W-1:0]    word_data;
`ifdef RO_DEMUX_LAST_EN
    logic [N_CH-1:0] ch_last;
`endif

    modport master (
        output en, sync, bus_in,
        input  slot_valid, slot_ch, slot_bit,
        input  word_valid, word_ch, word_data
`ifdef RO_DEMUX_LAST_EN
        , input ch_last
`endif
    );

    modport slave (
        input  en, sync, bus_in,
        output slot_valid, slot_ch, slot_bit,
        output word_valid, word_ch, word_data
`ifdef RO_DEMUX_LAST_EN
        , output ch_last
`endif
    );

endinterface

// File: rtl/ro_slot_dec.sv
// Slot owner decoder: trailing-ones priority encoder of the local count.
// All-ones count is the idle slot where no channel drives the bus.
module ro_slot_dec
    import ro_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] i_cnt,
    output logic            o_idle,
    output logic [CH_W-1:0] o_k
);

    assign o_idle = &i_cnt;
    assign o_k    = CH_W'(tones(32'(i_cnt), N_CH));

endmodule

// File: rtl/ro_demux.sv
// Readout-bus deserializer: tracks the gray slot owner, packs W-bit words.
// Build option RO_DEMUX_LAST_EN adds ch_last (most recent bit per channel).
module ro_demux
    import ro_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int W      = W_DEF,
    parameter int CH_W   = ch_w(N_CH),
    parameter int FILL_W = fill_w(W)
) (
    input  logic     clk_ext,
    input  logic     reset,
    ro_demux_if.slave rb
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]   r_cnt;
    // MSB of a full word is never kept: the word is emitted as it completes
    logic [W-2:0]      r_sr   [N_CH];
    logic [FILL_W-1:0] r_fill [N_CH];
    logic              r_slot_valid;
    logic [CH_W-1:0]   r_slot_ch;
    logic              r_slot_bit;
    logic              r_word_valid;
    logic [CH_W-1:0]   r_word_ch;
    logic [W-1:0]      r_word_data;

    logic              w_idle;
    logic [CH_W-1:0]   w_k;
    logic [IDX_W-1:0]  w_idx;
    logic              w_take;
    logic              w_last;

    ro_slot_dec #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_dec (
        .i_cnt  (r_cnt),
        .o_idle (w_idle),
        .o_k    (w_k)
    );

    assign w_idx  = w_k[IDX_W-1:0];
    assign w_take = rb.en & ~w_idle;
    assign w_last = (r_fill[w_idx] == FILL_W'(W - 1));

    always_ff @(posedge clk_ext) begin
        if (reset) begin
            r_cnt        <= '0;
            r_slot_valid <= 1'b0;
            r_slot_ch    <= '0;
            r_slot_bit   <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_ch    <= '0;
            r_word_data  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_sr[i]   <= '0;
                r_fill[i] <= '0;
            end
        end else begin
            r_slot_valid <= 1'b0;
            r_word_valid <= 1'b0;
            if (rb.sync) begin
                r_cnt <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    r_fill[i] <= '0;
                end
            end else if (rb.en) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_take) begin
                    r_sr[w_idx]  <= (W-1)'({r_sr[w_idx], rb.bus_in});
                    r_slot_valid <= 1'b1;
                    r_slot_ch    <= w_k;
                    r_slot_bit   <= rb.bus_in;
                    if (w_last) begin
                        r_fill[w_idx] <= '0;
                        r_word_valid  <= 1'b1;
                        r_word_ch     <= w_k;
                        r_word_data   <= {r_sr[w_idx], rb.bus_in};
                    end else begin
                        r_fill[w_idx] <= r_fill[w_idx] + FILL_W'(1);
                    end
                end
            end
        end
    end

    assign rb.slot_valid = r_slot_valid;
    assign rb.slot_ch    = r_slot_ch;
    assign rb.slot_bit   = r_slot_bit;
    assign rb.word_valid = r_word_valid;
    assign rb.word_ch    = r_word_ch;
    assign rb.word_data  = r_word_data;

`ifdef RO_DEMUX_LAST_EN
    logic [N_CH-1:0] r_ch_last;

    always_ff @(posedge clk_ext) begin
        if (reset) begin
            r_ch_last <= '0;
        end else if (!rb.sync && w_take) begin
            r_ch_last[w_idx] <= rb.bus_in;
        end
    end

    assign rb.ch_last = r_ch_last;
`endif

endmodule

// File: tb/tb_ro_demux.sv
// Bench for ro_demux (N_CH=4, W=4): fixed vector table, corner sequences,
// and random traffic against a queue-based slot/word model.
module tb_ro_demux;

    localparam int N  = 4;
    localparam int WW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ro_demux_if #(.N_CH(N), .W(WW)) rb ();

    ro_demux #(.N_CH(N), .W(WW)) dut (
        .clk_ext (clk),
        .reset   (reset),
        .rb      (rb)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] in;
        logic       sv;
        logic [2:0] sch;
        logic       wv;
        logic [2:0] wch;
        logic [3:0] wd;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in, input logic sv,
                                input logic [2:0] sch, input logic wv,
                                input logic [2:0] wch, input logic [3:0] wd);
        vec_t v;
        v.in  = in;
        v.sv  = sv;
        v.sch = sch;
        v.wv  = wv;
        v.wch = wch;
        v.wd  = wd;
        return v;
    endfunction

    vec_t tbl [18];

    // Model: count as an integer, one FIFO of samples per channel
    int m_cnt;
    bit m_q [N][$];
    bit e_sv, e_sb, e_wv, e_all;
    int e_sch, e_wch, e_wd;

    function automatic int ref_tones(input int c);
        int k;
        k = 0;
        while (k < N && c[k]) k++;
        return k;
    endfunction

    task automatic model(input logic r, s, e, b);
        e_all = 0;
        e_sv  = 0;
        e_wv  = 0;
        if (r) begin
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_q[i].delete();
            e_all = 1;
            e_sch = 0;
            e_sb  = 0;
            e_wch = 0;
            e_wd  = 0;
        end else if (s) begin
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_q[i].delete();
        end else if (e) begin
            int k;
            k = ref_tones(m_cnt);
            m_cnt = (m_cnt + 1) % (1 << N);
            if (k < N) begin
                m_q[k].push_back(b);
                e_sv  = 1;
                e_sch = k;
                e_sb  = b;
                if (m_q[k].size() == WW) begin
                    e_wv  = 1;
                    e_wch = k;
                    e_wd  = 0;
                    foreach (m_q[k][j]) e_wd = (e_wd << 1) | int'(m_q[k][j]);
                    m_q[k].delete();
                end
            end
        end
    endtask

    task automatic cyc(input logic r, s, e, b, input string tag);
        reset     = r;
        rb.sync   = s;
        rb.en     = e;
        rb.bus_in = b;
        model(r, s, e, b);
        @(posedge clk);
        #1;
        chk({tag, ".slot_valid"}, int'(rb.slot_valid), int'(e_sv));
        chk({tag, ".word_valid"}, int'(rb.word_valid), int'(e_wv));
        if (e_sv || e_all) begin
            chk({tag, ".slot_ch"}, int'(rb.slot_ch), e_sch);
            chk({tag, ".slot_bit"}, int'(rb.slot_bit), int'(e_sb));
        end
        if (e_wv || e_all) begin
            chk({tag, ".word_ch"}, int'(rb.word_ch), e_wch);
            chk({tag, ".word_data"}, int'(rb.word_data), e_wd);
        end
    endtask

    initial begin
        // in = {reset, sync, en, bus_in}; ch0 bits 1,0,1,1 then 0s,
        // ch1 ones at c=1,5,9,13, c=15 idle, then wrap to c=0
        tbl[0]  = mk(4'b1000, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[1]  = mk(4'b0011, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[2]  = mk(4'b0011, 1'b1, 3'd1, 1'b0, 3'd0, 4'b0000);
        tbl[3]  = mk(4'b0010, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[4]  = mk(4'b0010, 1'b1, 3'd2, 1'b0, 3'd0, 4'b0000);
        tbl[5]  = mk(4'b0011, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[6]  = mk(4'b0011, 1'b1, 3'd1, 1'b0, 3'd0, 4'b0000);
        tbl[7]  = mk(4'b0011, 1'b1, 3'd0, 1'b1, 3'd0, 4'b1011);
        tbl[8]  = mk(4'b0010, 1'b1, 3'd3, 1'b0, 3'd0, 4'b0000);
        tbl[9]  = mk(4'b0010, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[10] = mk(4'b0011, 1'b1, 3'd1, 1'b0, 3'd0, 4'b0000);
        tbl[11] = mk(4'b0010, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[12] = mk(4'b0010, 1'b1, 3'd2, 1'b0, 3'd0, 4'b0000);
        tbl[13] = mk(4'b0010, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[14] = mk(4'b0011, 1'b1, 3'd1, 1'b1, 3'd1, 4'b1111);
        tbl[15] = mk(4'b0010, 1'b1, 3'd0, 1'b1, 3'd0, 4'b0000);
        tbl[16] = mk(4'b0011, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000);
        tbl[17] = mk(4'b0010, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000);

        for (int i = 0; i < 18; i++) begin
            {reset, rb.sync, rb.en, rb.bus_in} = tbl[i].in;
            @(posedge clk);
            #1;
            chk($sformatf("tbl[%0d].slot_valid", i),
                int'(rb.slot_valid), int'(tbl[i].sv));
            chk($sformatf("tbl[%0d].word_valid", i),
                int'(rb.word_valid), int'(tbl[i].wv));
            if (tbl[i].sv || tbl[i].in[3]) begin
                chk($sformatf("tbl[%0d].slot_ch", i),
                    int'(rb.slot_ch), int'(tbl[i].sch));
                chk($sformatf("tbl[%0d].slot_bit", i),
                    int'(rb.slot_bit), int'(tbl[i].in[0]));
            end
            if (tbl[i].wv || tbl[i].in[3]) begin
                chk($sformatf("tbl[%0d].word_ch", i),
                    int'(rb.word_ch), int'(tbl[i].wch));
                chk($sformatf("tbl[%0d].word_data", i),
                    int'(rb.word_data), int'(tbl[i].wd));
            end
        end

        // sync at c=5 with ch0 half full of ones; next ch0 word must be clean
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "A.rst");
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b1, (c % 2) == 0, "A.pre");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, "A.sync");
        for (int c = 0; c < 7; c++) cyc(1'b0, 1'b0, 1'b1, c == 2 || c == 4, "A.post");
        chk("A.word_valid_c6", int'(rb.word_valid), 1);
        chk("A.word_ch_c6", int'(rb.word_ch), 0);
        chk("A.word_data_c6", int'(rb.word_data), 6);

        // three-cycle en gap at c=3; ch2 slot resumes afterwards
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "B.rst");
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b1, 1'b0, "B.pre");
        for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "B.gap");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "B.c3");
        chk("B.resume_valid", int'(rb.slot_valid), 1);
        chk("B.resume_ch", int'(rb.slot_ch), 2);

        // reset together with sync and en mid-stream
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "C.rst");
        for (int c = 0; c < 7; c++) cyc(1'b0, 1'b0, 1'b1, 1'b1, "C.pre");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "C.all");
        chk("C.word_data_zero", int'(rb.word_data), 0);
        chk("C.slot_ch_zero", int'(rb.slot_ch), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "C.first");
        chk("C.first_valid", int'(rb.slot_valid), 1);
        chk("C.first_ch", int'(rb.slot_ch), 0);

        // random traffic
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "R.rst");
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 79) == 0,
                $urandom_range(0, 9) != 0,
                1'($urandom),
                $sformatf("R[%0d]", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_demux.md
Name: ro_demux

Overview:
Receive-side deserializer for the shared readout bus that the ro_block tristate stages drive.
- Keeps a local binary slot counter aligned to the transmitter's gray counter.
- Each cycle, decodes which channel owns the bus. The owner is the gray bit that toggles, equal to the count of trailing ones in the binary count.
- Shifts the sampled bit into that channel's word register and emits a completed word when W samples have been gathered.
- Sits between the readout bus retiming flop and the digital back-end / SPI framer.

Parameters:
N_CH, 17, number of readout channels (= transmitter gray counter width); channel k corresponds to gray bit k.
W, 8, samples per output word per channel.
CH_W, $clog2(N_CH+1), width of channel index.
FILL_W, $clog2(W+1), width of per-channel fill counter.

Ports:
clk_ext  in  1  single global clock; same clock that drives the transmitter gray counter.
reset  in  1  synchronous, active-high reset.
en  in  1  counter/sample enable; mirrors the transmitter gray counter enable.
sync  in  1  synchronous realign pulse; issued in the same cycle the transmitter gray counter is reset.
bus_in  in  1  retimed shared readout bus; at the edge where local count = c, it carries the slot of channel tones(c).
slot_valid  out  1  registered; a channel slot was sampled last cycle.
slot_ch  out  CH_W  registered channel index of the last sample.
slot_bit  out  1  registered value of the last sample.
word_valid  out  1  one-cycle strobe; a channel word is complete.
word_ch  out  CH_W  channel of the completed word.
word_data  out  W  completed word; oldest sample in MSB, newest in LSB.

Behaviour:
- Reset (reset=1 at posedge):
  - cnt=0.
  - All shift registers and fill counters are 0.
  - All outputs are 0.
  - reset has priority over sync and en.
- sync=1 (no reset):
  - cnt<=0.
  - All fill counters <=0; shift registers are left as is (don't care).
  - No sample is taken that cycle; slot_valid<=0, word_valid<=0.
- en=0: cnt holds, no sample, slot_valid<=0, word_valid<=0.
- en=1, normal cycle with count c:
  - k = tones(c), the number of trailing ones of c, range 0..N_CH.
  - cnt <= c+1, with natural wrap modulo 2^N_CH.
  - If k<N_CH: sample bus_in into channel k:
    - sr[k] <= {sr[k][W-2:0], bus_in}; fill[k] <= fill[k]+1.
    - Next cycle: slot_valid=1, slot_ch=k, slot_bit=bus_in.
  - If k==N_CH (c all ones): idle slot, no channel drives; slot_valid<=0, bus_in is ignored.
- Word completion:
  - When fill[k]==W-1 and channel k is sampled, fill[k]<=0.
  - Next cycle: word_valid=1, word_ch=k, word_data={sr[k][W-2:0],bus_in}.
  - At most one channel is sampled per cycle, so word completions never collide; no arbitration is needed.
- Latency: bus_in to slot_* / word_* is exactly 1 cycle.
- Stream interface with no backpressure. word_valid is a one-cycle pulse; the consumer must capture it.
- Channel k sample rate = f(clk_ext)/2^(k+1). Channel k's first slot after sync is at c = 2^k - 1.

Optional Feature:
RO_DEMUX_LAST_EN
- Defined: adds output ch_last[N_CH], a per-channel register of the most recent sampled bit.
  - Updated in the same cycle as the slot_* outputs.
  - Reset to 0; unaffected by sync.
- Undefined: the port and registers are absent; all other behaviour is identical.

Decomposition:
- Package ro_pkg:
  - default N_CH/W constants;
  - function tones() (trailing-ones count);
  - CH_W/FILL_W derivation helpers.
- Sub-module ro_slot_dec: combinational trailing-ones priority encoder, cnt -> {idle, k}. Instantiated once.

Test Plan (N_CH=4, W=4 unless noted):
- Reset then en=1, bus_in=0: slot_ch sequence is 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0, then slot_valid=0 (idle at c=15); the sequence repeats.
- bus_in=1 only in ch1 slots (c=1,5,9,13): word_valid=1 in the cycle after c=13 with word_ch=1, word_data=4'b1111. Also a ch0 word after c=6 with word_data=4'b0000.
- ch0 pattern 1,0,1,1 across c=0,2,4,6 -> the cycle after c=6 shows word_ch=0, word_data=4'b1011.
- sync asserted at c=5 mid-word -> cnt=0 next and fills cleared. The next ch0 word completes 4 ch0 slots later (after new c=6), with no stale bits.
- en=0 for 3 cycles at c=3 -> no slot_valid/word_valid during the gap; the sequence resumes at c=3 (ch2) unchanged.
- reset asserted together with sync and en mid-stream -> all outputs 0 next cycle; the first slot after release is ch0 at c=0.
